stopwatch_lap_core: RTL

//  Parametrised stopwatch/timer core: prescaled centisecond counter, count-up or countdown mode,
//  and a LAP_DEPTH-entry lap memory with recall. Drives a time value to the sevenseg display layer
//  and a status vector to the LEDs. Buttons arrive raw and active-low; all logic runs on clk only.

---
 rtl/stopwatch_lap_core_pkg.sv | 28 ++
 rtl/stopwatch_lap_core_lap_buffer.sv | 44 ++++
 rtl/stopwatch_lap_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_lap_core_pkg.sv
// Shared definitions for the stopwatch core: FSM state encodings, default
// timing constants, button-event bundle and the LED spot decoder.
package stopwatch_lap_core_pkg;

  localparam int DEF_TICK_DIV = 500000;  // 50 MHz -> 1 cs
  localparam int DEF_MAX_TIME = 359999;  // 59:59.99 in centiseconds

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One-cycle button events after synchronisation and edge detection.
  typedef struct packed {
    logic start;
    logic lap;
  } btn_ev_t;

  // Walking spot: the seconds digit (t/100 mod 10) selects one LED, led[9] at 0.
  function automatic logic [9:0] led_spot(input logic [31:0] t);
    logic [3:0] digit;
    digit = 4'((t / 32'd100) % 32'd10);
    return 10'b10_0000_0000 >> digit;
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_lap_buffer.sv
// Lap memory: DEPTH x TW register file with a saturating fill count.
//  clk, rst_n : clock, async active-low reset (clears count only)
//  clr        : synchronous count clear (new run)
//  wr_en      : store wr_data at slot count; ignored once full
//  rd_idx     : combinational read index -> rd_data
//  count      : number of laps stored, saturates at DEPTH
module stopwatch_lap_core_lap_buffer #(
  parameter int DEPTH = 8,
  parameter int LW    = 3,
  parameter int TW    = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_data,
  input  logic [LW-1:0] rd_idx,
  output logic [TW-1:0] rd_data,
  output logic [LW:0]   count
);

  logic [DEPTH-1:0][TW-1:0] mem;
  logic                     full;
  logic                     wr_ok;

  // DEPTH is a power of two, so the count MSB alone flags "full".
  assign full  = count[LW];
  assign wr_ok = wr_en && !full && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (wr_ok) count <= count + (LW+1)'(1);
  end

  // Contents are never read before being written in the current run,
  // so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[LW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: prescaled count-up/countdown timer with lap memory
// and recall, feeding the seven-segment layer and the status LEDs.
//  clk, key3     : clock, async active-low reset
//  start_n,lap_n : raw active-low buttons (start/pause/resume, lap/recall)
//  mode_down     : countdown select, sampled on IDLE->RUN
//  preset_time   : countdown start value
//  time_display  : registered live counter or recalled lap
//  led           : walking spot in RUN/PAUSE, all on in DONE, off in IDLE
//  lap_count, lap_sel, recall, done : lap memory and timer status
module stopwatch_lap_core
  import stopwatch_lap_core_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int TW        = 19,
  parameter int MAX_TIME  = DEF_MAX_TIME,
  parameter int LAP_DEPTH = 8,
  parameter int LW        = 3
) (
  input  logic          clk,
  input  logic          key3,
  input  logic          start_n,
  input  logic          lap_n,
  input  logic          mode_down,
  input  logic [TW-1:0] preset_time,
  output logic [TW-1:0] time_display,
  output logic [9:0]    led,
  output logic [LW:0]   lap_count,
  output logic [LW-1:0] lap_sel,
  output logic          recall,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // [0],[1] synchronise; [2] holds the previous synced level for edge detect.
  logic [2:0] start_pipe, lap_pipe;
  btn_ev_t    ev;

  state_t        state, state_nxt;
  logic [TW-1:0] counter, cnt_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          down_q, down_nxt;
  logic          recall_nxt, done_nxt;
  logic [LW-1:0] sel_nxt;
  logic          tick;
  logic          lap_wr, lap_clr;
  logic [TW-1:0] lap_rd;

  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      start_pipe <= '1;
      lap_pipe   <= '1;
    end else begin
      start_pipe <= {start_pipe[1:0], start_n};
      lap_pipe   <= {lap_pipe[1:0], lap_n};
    end
  end

  // Start has priority: a coincident lap event is dropped.
  always_comb begin
    ev       = '0;
    ev.start = start_pipe[2] & ~start_pipe[1];
    ev.lap   = lap_pipe[2] & ~lap_pipe[1] & ~ev.start;
  end

  stopwatch_lap_core_lap_buffer #(
    .DEPTH (LAP_DEPTH),
    .LW    (LW),
    .TW    (TW)
  ) u_laps (
    .clk     (clk),
    .rst_n   (key3),
    .clr     (lap_clr),
    .wr_en   (lap_wr),
    .wr_data (counter),
    .rd_idx  (lap_sel),
    .rd_data (lap_rd),
    .count   (lap_count)
  );

  assign tick = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge key3) begin
    if (!key3) begin
      state        <= ST_IDLE;
      counter      <= '0;
      presc        <= '0;
      down_q       <= 1'b0;
      recall       <= 1'b0;
      lap_sel      <= '0;
      done         <= 1'b0;
      time_display <= '0;
    end else begin
      state        <= state_nxt;
      counter      <= cnt_nxt;
      presc        <= presc_nxt;
      down_q       <= down_nxt;
      recall       <= recall_nxt;
      lap_sel      <= sel_nxt;
      done         <= done_nxt;
      time_display <= recall ? lap_rd : counter;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = counter;
    presc_nxt  = presc;
    down_nxt   = down_q;
    recall_nxt = recall;
    sel_nxt    = lap_sel;
    done_nxt   = done;
    lap_wr     = 1'b0;
    lap_clr    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        presc_nxt = '0;
        if (ev.start) begin
          state_nxt  = ST_RUN;
          down_nxt   = mode_down;
          cnt_nxt    = mode_down ? preset_time : '0;
          lap_clr    = 1'b1;
          recall_nxt = 1'b0;
        end else if (ev.lap && lap_count != '0) begin
          recall_nxt = 1'b1;
          sel_nxt    = (!recall || ({1'b0, lap_sel} + (LW+1)'(1) == lap_count))
                       ? '0 : lap_sel + LW'(1);
        end
      end
      ST_RUN: begin
        if (ev.start) begin
          // Pause freezes everything, including this cycle's prescaler step.
          state_nxt = ST_PAUSE;
        end else begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          lap_wr    = ev.lap;
          if (tick) begin
            if (down_q) begin
              // <=1 so a zero preset also terminates on the first tick.
              if (counter <= TW'(1)) begin
                state_nxt = ST_DONE;
                cnt_nxt   = '0;
                done_nxt  = 1'b1;
              end else begin
                cnt_nxt = counter - TW'(1);
              end
            end else begin
              cnt_nxt = (counter == TW'(MAX_TIME)) ? '0 : counter + TW'(1);
            end
          end
        end
      end
      ST_PAUSE: begin
        if (ev.start) begin
          state_nxt  = ST_RUN;
          recall_nxt = 1'b0;
        end else if (ev.lap && lap_count != '0) begin
          recall_nxt = 1'b1;
          sel_nxt    = (!recall || ({1'b0, lap_sel} + (LW+1)'(1) == lap_count))
                       ? '0 : lap_sel + LW'(1);
        end
      end
      ST_DONE: begin
        if (ev.start) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    led = '0;
    unique case (state)
      ST_RUN, ST_PAUSE: led = led_spot(32'(counter));
      ST_DONE:          led = '1;
      default:          led = '0;
    endcase
  end

endmodule
